branch_predictor: RTL and testbench

- Parametrised branch prediction unit for the pipelined core. Replaces the purely combinational branch-condition block.
- Provides a direct-mapped branch target buffer (BTB) with saturating counters, looked up in IF.
- Resolves branches from the flag-based 3-bit condition codes and reports a mispredict plus redirect PC to the pipeline control.
- Keeps saturating performance counters.

---
 rtl/branch_predictor_if.sv | 41 ++++
 rtl/branch_predictor.sv | 129 ++++++++++++
 tb/tb_branch_predictor.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Bus between the pipeline and the branch predictor: fetch-side lookup,
// resolve-side update/redirect, and the performance counter port.
interface branch_predictor_if #(
    parameter int ADDR_W = 16,
    parameter int STAT_W = 16
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_next_pc;

    logic              upd_valid;
    logic              upd_is_branch;
    logic [ADDR_W-1:0] upd_pc;
    logic [2:0]        upd_cond;
    logic [2:0]        upd_flags;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_pc;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    logic              stat_clr;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    // Pipeline side: drives fetch PC and resolving instruction, reads predictions
    modport master (
        output if_pc, upd_valid, upd_is_branch, upd_pc, upd_cond, upd_flags,
               upd_target, upd_pred_taken, upd_pred_pc, stat_clr,
        input  pred_taken, pred_next_pc, mispredict, redirect_pc,
               stat_branches, stat_mispred
    );

    // Predictor side
    modport slave (
        input  if_pc, upd_valid, upd_is_branch, upd_pc, upd_cond, upd_flags,
               upd_target, upd_pred_taken, upd_pred_pc, stat_clr,
        output pred_taken, pred_next_pc, mispredict, redirect_pc,
               stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters, flag-based branch resolution
// with mispredict/redirect, and saturating performance counters.
module branch_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [STAT_W-1:0]  stat_branches_q;
    logic [STAT_W-1:0]  stat_mispred_q;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    logic               cond_true;
    logic               actual_taken;
    logic [ADDR_W-1:0]  correct_pc;
    logic               mispredict;

    // The carried prediction bit is implied by upd_pred_pc, which alone decides correctness
    logic               unused_pred_taken;
    assign unused_pred_taken = bp.upd_pred_taken;

    // Fetch-side lookup; reads pre-edge table contents, no bypass from the update port
    assign lk_idx          = bp.if_pc[IDX_W-1:0];
    assign lk_tag          = bp.if_pc[ADDR_W-1:IDX_W];
    assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.pred_taken   = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign bp.pred_next_pc = bp.pred_taken ? target_q[lk_idx] : bp.if_pc + PC_ONE;

    assign up_idx = bp.upd_pc[IDX_W-1:0];
    assign up_tag = bp.upd_pc[ADDR_W-1:IDX_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Branch condition from the {N,V,Z} flags
    always_comb begin
        cond_true = 1'b0;
        case (bp.upd_cond)
            3'b000:  cond_true = ~bp.upd_flags[0];
            3'b001:  cond_true = bp.upd_flags[0];
            3'b010:  cond_true = ~(bp.upd_flags[0] | bp.upd_flags[2]);
            3'b011:  cond_true = bp.upd_flags[2];
            3'b100:  cond_true = bp.upd_flags[0] | ~bp.upd_flags[2];
            3'b101:  cond_true = bp.upd_flags[2] | bp.upd_flags[0];
            3'b110:  cond_true = bp.upd_flags[1];
            default: cond_true = 1'b1;
        endcase
    end

    assign actual_taken   = bp.upd_is_branch & cond_true;
    assign correct_pc     = actual_taken ? bp.upd_target : bp.upd_pc + PC_ONE;
    assign mispredict     = bp.upd_valid & (bp.upd_pred_pc != correct_pc);
    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = correct_pc;

    // BTB training: strengthen/allocate on taken, weaken on not-taken, drop aliased non-branches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (bp.upd_valid) begin
            if (bp.upd_is_branch) begin
                if (actual_taken) begin
                    if (up_hit) begin
                        if (ctr_q[up_idx] != CTR_MAX) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
                        end
                        target_q[up_idx] <= bp.upd_target;
                    end else begin
                        valid_q[up_idx]  <= 1'b1;
                        tag_q[up_idx]    <= up_tag;
                        target_q[up_idx] <= bp.upd_target;
                        ctr_q[up_idx]    <= (bp.upd_cond == 3'b111) ? CTR_MAX : CTR_WEAK;
                    end
                end else if (up_hit && (ctr_q[up_idx] != '0)) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (up_hit) begin
                valid_q[up_idx] <= 1'b0;
            end
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (bp.stat_clr) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (bp.upd_valid && bp.upd_is_branch && (stat_branches_q != '1)) begin
                stat_branches_q <= stat_branches_q + STAT_W'(1);
            end
            if (mispredict && (stat_mispred_q != '1)) begin
                stat_mispred_q <= stat_mispred_q + STAT_W'(1);
            end
        end
    end

    assign bp.stat_branches = stat_branches_q;
    assign bp.stat_mispred  = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: scripted corner cases, a condition-code
// vector table, and randomized traffic against an abstract BTB model.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int CTR_MAXV = 3;
    localparam int CTR_WEAKV = 2;
    localparam int STAT_MAXV = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared = 0;
    int mismatched = 0;

    branch_predictor_if #(.ADDR_W(16), .STAT_W(16)) bp ();

    branch_predictor #(
        .ADDR_W(16), .ENTRIES(ENTRIES), .CTR_W(2), .STAT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    always #5 clk = ~clk;

    // Abstract model: each slot remembers the full PC it was trained on
    bit m_valid [ENTRIES];
    int m_pc    [ENTRIES];
    int m_tgt   [ENTRIES];
    int m_ctr   [ENTRIES];
    int m_branches;
    int m_mispred;

    typedef struct {
        logic [2:0] cond;
        logic [2:0] flags;
        bit         taken;
    } cond_vec_t;

    cond_vec_t vecs [18];

    function automatic int incPc(input int pc);
        return (pc + 1) & 16'hFFFF;
    endfunction

    function automatic bit condTrue(input logic [2:0] cond, input logic [2:0] flags);
        bit n, v, z;
        n = flags[2];
        v = flags[1];
        z = flags[0];
        case (cond)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void modelLookup(input int pc, output bit tk, output int nxt);
        int e;
        e = pc % ENTRIES;
        tk = m_valid[e] && (m_pc[e] == pc) && (m_ctr[e] >= CTR_WEAKV);
        nxt = tk ? m_tgt[e] : incPc(pc);
    endfunction

    function automatic int modelCorrect();
        bit tk;
        tk = bp.upd_is_branch && condTrue(bp.upd_cond, bp.upd_flags);
        return tk ? int'(bp.upd_target) : incPc(int'(bp.upd_pc));
    endfunction

    function automatic bit modelMispredict();
        return bp.upd_valid && (int'(bp.upd_pred_pc) != modelCorrect());
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_pc[i] = 0;
            m_tgt[i] = 0;
            m_ctr[i] = 0;
        end
        m_branches = 0;
        m_mispred = 0;
    endtask

    // Applies the state change implied by the inputs present at a clock edge
    task automatic modelEdge();
        int e, pc;
        bit hit, tk, mp;
        mp = modelMispredict();
        if (bp.stat_clr) begin
            m_branches = 0;
            m_mispred = 0;
        end else begin
            if (bp.upd_valid && bp.upd_is_branch && m_branches < STAT_MAXV) m_branches++;
            if (mp && m_mispred < STAT_MAXV) m_mispred++;
        end
        if (bp.upd_valid) begin
            pc = int'(bp.upd_pc);
            e = pc % ENTRIES;
            hit = m_valid[e] && (m_pc[e] == pc);
            tk = bp.upd_is_branch && condTrue(bp.upd_cond, bp.upd_flags);
            if (bp.upd_is_branch) begin
                if (tk && hit) begin
                    if (m_ctr[e] < CTR_MAXV) m_ctr[e]++;
                    m_tgt[e] = int'(bp.upd_target);
                end else if (tk) begin
                    m_valid[e] = 1;
                    m_pc[e] = pc;
                    m_tgt[e] = int'(bp.upd_target);
                    m_ctr[e] = (bp.upd_cond == 3'b111) ? CTR_MAXV : CTR_WEAKV;
                end else if (hit && m_ctr[e] > 0) begin
                    m_ctr[e]--;
                end
            end else if (hit) begin
                m_valid[e] = 0;
            end
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compares every output against the model for the inputs currently applied
    task automatic checkOutput(input string tag);
        bit tk;
        int nxt;
        modelLookup(int'(bp.if_pc), tk, nxt);
        checkVal({tag, ".pred_taken"}, int'(bp.pred_taken), int'(tk));
        checkVal({tag, ".pred_next_pc"}, int'(bp.pred_next_pc), nxt);
        checkVal({tag, ".mispredict"}, int'(bp.mispredict), int'(modelMispredict()));
        checkVal({tag, ".redirect_pc"}, int'(bp.redirect_pc), modelCorrect());
        checkVal({tag, ".stat_branches"}, int'(bp.stat_branches), m_branches);
        checkVal({tag, ".stat_mispred"}, int'(bp.stat_mispred), m_mispred);
    endtask

    // Drives one cycle's inputs shortly after the rising edge and lets them settle
    task automatic applyStimulus(input bit v, input bit br, input int pc, input int cond,
                                 input int flags, input int tgt, input int ppc,
                                 input bit clr, input int ifpc);
        bp.upd_valid      = v;
        bp.upd_is_branch  = br;
        bp.upd_pc         = 16'(pc);
        bp.upd_cond       = 3'(cond);
        bp.upd_flags      = 3'(flags);
        bp.upd_target     = 16'(tgt);
        bp.upd_pred_pc    = 16'(ppc);
        bp.upd_pred_taken = (ppc != incPc(pc));
        bp.stat_clr       = clr;
        bp.if_pc          = 16'(ifpc);
        #2;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        if (!rst) modelEdge();
        #1;
    endtask

    task automatic idle(input int ifpc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ifpc);
    endtask

    function automatic int pickPc();
        if ($urandom_range(0, 19) == 0) return 16'hFFFF;
        return ($urandom_range(0, 2) << 4) | $urandom_range(0, 15);
    endfunction

    initial begin
        vecs[0]  = '{3'd0, 3'b000, 1'b1};
        vecs[1]  = '{3'd0, 3'b001, 1'b0};
        vecs[2]  = '{3'd1, 3'b001, 1'b1};
        vecs[3]  = '{3'd1, 3'b110, 1'b0};
        vecs[4]  = '{3'd2, 3'b000, 1'b1};
        vecs[5]  = '{3'd2, 3'b100, 1'b0};
        vecs[6]  = '{3'd2, 3'b001, 1'b0};
        vecs[7]  = '{3'd3, 3'b100, 1'b1};
        vecs[8]  = '{3'd3, 3'b011, 1'b0};
        vecs[9]  = '{3'd4, 3'b000, 1'b1};
        vecs[10] = '{3'd4, 3'b100, 1'b0};
        vecs[11] = '{3'd4, 3'b101, 1'b1};
        vecs[12] = '{3'd5, 3'b010, 1'b0};
        vecs[13] = '{3'd5, 3'b001, 1'b1};
        vecs[14] = '{3'd5, 3'b100, 1'b1};
        vecs[15] = '{3'd6, 3'b010, 1'b1};
        vecs[16] = '{3'd6, 3'b101, 1'b0};
        vecs[17] = '{3'd7, 3'b000, 1'b1};

        modelReset();
        rst = 1'b1;
        idle(16'h0010);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        idle(16'h0010);
        checkVal("rst.pred_taken", int'(bp.pred_taken), 0);
        checkVal("rst.pred_next_pc", int'(bp.pred_next_pc), 16'h0011);
        checkVal("rst.stat_branches", int'(bp.stat_branches), 0);
        checkVal("rst.stat_mispred", int'(bp.stat_mispred), 0);
        checkOutput("rst");
        clockEdge();

        // First taken EQ branch allocates and mispredicts
        applyStimulus(1, 1, 16'h0010, 1, 3'b001, 16'h0040, 16'h0011, 0, 16'h0010);
        checkVal("alloc.mispredict", int'(bp.mispredict), 1);
        checkVal("alloc.redirect_pc", int'(bp.redirect_pc), 16'h0040);
        checkVal("alloc.same_cycle_no_bypass", int'(bp.pred_taken), 0);
        checkOutput("alloc");
        clockEdge();
        idle(16'h0010);
        checkVal("alloc_next.pred_taken", int'(bp.pred_taken), 1);
        checkVal("alloc_next.pred_next_pc", int'(bp.pred_next_pc), 16'h0040);
        checkVal("alloc_next.stat_mispred", int'(bp.stat_mispred), 1);
        checkOutput("alloc_next");
        clockEdge();

        // Counter walks down and floors at zero, then one taken is not enough
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 16'h0010, 1, 3'b000, 16'h0040, 16'h0011, 0, 16'h0010);
            checkOutput("nt_walk");
            clockEdge();
            if (i == 0) begin
                idle(16'h0010);
                checkVal("nt_first.pred_taken", int'(bp.pred_taken), 0);
            end
        end
        applyStimulus(1, 1, 16'h0010, 1, 3'b001, 16'h0040, 16'h0011, 0, 16'h0010);
        checkOutput("tk_after_floor");
        clockEdge();
        idle(16'h0010);
        checkVal("tk_after_floor.pred_taken", int'(bp.pred_taken), 0);
        checkOutput("tk_after_floor_look");
        clockEdge();

        // Aliasing on the same index replaces the entry; non-branch invalidates
        applyStimulus(1, 1, 16'h0003, 7, 0, 16'h0080, 16'h0004, 0, 16'h0003);
        checkOutput("alias_a");
        clockEdge();
        applyStimulus(1, 1, 16'h0013, 7, 0, 16'h0090, 16'h0014, 0, 16'h0003);
        checkVal("alias_a.pred_taken", int'(bp.pred_taken), 1);
        checkOutput("alias_b");
        clockEdge();
        idle(16'h0003);
        checkVal("alias_old.pred_taken", int'(bp.pred_taken), 0);
        checkOutput("alias_old");
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0013);
        checkVal("alias_new.pred_taken", int'(bp.pred_taken), 1);
        checkVal("alias_new.pred_next_pc", int'(bp.pred_next_pc), 16'h0090);
        clockEdge();
        applyStimulus(1, 0, 16'h0013, 7, 0, 16'h0090, 16'h0090, 0, 16'h0013);
        checkVal("nonbr.mispredict", int'(bp.mispredict), 1);
        checkVal("nonbr.redirect_pc", int'(bp.redirect_pc), 16'h0014);
        checkOutput("nonbr");
        clockEdge();
        idle(16'h0013);
        checkVal("nonbr_inval.pred_taken", int'(bp.pred_taken), 0);
        checkOutput("nonbr_inval");
        clockEdge();

        // PC wrap plus stat clear held across updates
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 16'hFFFF, 1, 3'b000, 16'h1234, 16'h0000, 1, 16'hFFFF);
            checkVal("wrap.mispredict", int'(bp.mispredict), 0);
            checkVal("wrap.redirect_pc", int'(bp.redirect_pc), 0);
            checkVal("wrap.pred_next_pc", int'(bp.pred_next_pc), 0);
            checkOutput("wrap");
            clockEdge();
        end
        idle(0);
        checkVal("clr.stat_branches", int'(bp.stat_branches), 0);
        checkVal("clr.stat_mispred", int'(bp.stat_mispred), 0);
        clockEdge();

        // Condition code table
        for (int i = 0; i < 18; i++) begin
            int pc, tgt;
            pc = 16'h0200 + i;
            tgt = 16'h0500 + i;
            applyStimulus(1, 1, pc, vecs[i].cond, vecs[i].flags, tgt, incPc(pc), 0, pc);
            checkVal($sformatf("cond%0d.mispredict", i), int'(bp.mispredict), int'(vecs[i].taken));
            checkVal($sformatf("cond%0d.redirect_pc", i), int'(bp.redirect_pc),
                     vecs[i].taken ? tgt : incPc(pc));
            checkOutput($sformatf("cond%0d", i));
            clockEdge();
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int pc, ppc, tgt, ifpc;
            bit ptk;
            pc = pickPc();
            ifpc = ($urandom_range(0, 1) == 0) ? pc : pickPc();
            tgt = ($urandom_range(0, 1) == 0) ? (16'h0100 | $urandom_range(0, 7)) : int'($urandom_range(0, 16'hFFFF));
            case ($urandom_range(0, 3))
                0: modelLookup(pc, ptk, ppc);
                1: modelLookup(pc, ptk, ppc);
                2: ppc = incPc(pc);
                default: ppc = tgt;
            endcase
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, pc,
                          $urandom_range(0, 7), $urandom_range(0, 7), tgt, ppc,
                          $urandom_range(0, 40) == 0, ifpc);
            checkOutput("rand");
            clockEdge();
        end

        // Asynchronous reset mid-cycle discards the coinciding update
        applyStimulus(1, 1, 16'h0025, 7, 0, 16'h0077, 16'h0026, 0, 16'h0025);
        clockEdge();
        applyStimulus(1, 1, 16'h0030, 7, 0, 16'h0066, 16'h0031, 0, 16'h0025);
        checkVal("pre_rst.pred_taken", int'(bp.pred_taken), 1);
        rst = 1'b1;
        modelReset();
        #1;
        checkVal("async_rst.pred_taken", int'(bp.pred_taken), 0);
        checkVal("async_rst.pred_next_pc", int'(bp.pred_next_pc), 16'h0026);
        checkVal("async_rst.stat_branches", int'(bp.stat_branches), 0);
        checkVal("async_rst.redirect_pc", int'(bp.redirect_pc), 16'h0066);
        checkOutput("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(16'h0030);
        checkVal("rst_drop.pred_taken", int'(bp.pred_taken), 0);
        checkVal("rst_drop.stat_branches", int'(bp.stat_branches), 0);
        checkOutput("rst_drop");
        clockEdge();
        idle(16'h0025);
        checkVal("rst_old.pred_taken", int'(bp.pred_taken), 0);
        clockEdge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
